// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and FSM state encoding for the UART boot loader.
package uart_boot_loader_pkg;

    localparam logic [7:0] MAGIC_DEF = 8'hA5;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_SEND,
        S_WAIT_TX,
        S_DONE
    } state_t;

endpackage

// File: rtl/uart_boot_loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT_CYC-th cycle. A clear in the expiry cycle suppresses it.
module uart_boot_loader_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    assign expire = en && !clr && (cnt == CW'(TIMEOUT_CYC - 1));

    // Outside a frame the counter rests at zero so each frame starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || !en)
            cnt <= '0;
        else if (!expire)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Frame parser that loads little-endian words into imem, checks an XOR
// checksum, answers ACK/NAK over the UART and releases the CPU after a good image.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                MAX_WORDS   = 1024,
    parameter int                TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]        MAGIC       = MAGIC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done_tick,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    state_t      state, state_n;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] idx;
    logic [1:0]  byte_cnt;
    logic [31:0] word_sr;
    logic [7:0]  csum;
    logic        send_now;
    logic [7:0]  send_byte;
    logic        tmo_en, expire;

    logic [15:0]       len_in;
    logic              len_bad;
    logic              last_word;
    logic [31:0]       word_next;
    logic [ADDR_W-1:0] word_addr;

    assign len_in    = {rx_data, len_lo};
    assign len_bad   = (len_in == 16'd0) || (32'(len_in) > MAX_WORDS);
    assign last_word = (idx + 16'd1 == len);
    // Bytes arrive LSB first, so shift in from the top.
    assign word_next = {rx_data, word_sr[31:8]};
    assign word_addr = BASE_ADDR + ADDR_W'({idx, 2'b00});
    assign tmo_en    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CSUM);

    uart_boot_loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rx_done_tick),
        .en     (tmo_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // A received byte always takes priority over a simultaneous timeout.
    always_comb begin
        state_n   = state;
        send_now  = 1'b0;
        send_byte = NAK;
        case (state)
            S_IDLE:    if (rx_done_tick && rx_data == MAGIC) state_n = S_LEN_LO;
            S_LEN_LO:  if (rx_done_tick) state_n = S_LEN_HI;
                       else if (expire) send_now = 1'b1;
            S_LEN_HI:  if (rx_done_tick) begin
                           if (len_bad) send_now = 1'b1;
                           else         state_n  = S_DATA;
                       end else if (expire) send_now = 1'b1;
            S_DATA:    if (rx_done_tick) begin
                           if (byte_cnt == 2'd3 && last_word) state_n = S_CSUM;
                       end else if (expire) send_now = 1'b1;
            S_CSUM:    if (rx_done_tick) begin
                           send_now = 1'b1;
                           if (rx_data == csum) send_byte = ACK;
                       end else if (expire) send_now = 1'b1;
            S_SEND:    state_n = S_WAIT_TX;
            S_WAIT_TX: if (tx_done_tick) state_n = (tx_data == ACK) ? S_DONE : S_IDLE;
            S_DONE:    state_n = S_DONE;
            default:   state_n = S_IDLE;
        endcase
        if (send_now) state_n = S_SEND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo    <= '0;
            len       <= '0;
            idx       <= '0;
            byte_cnt  <= '0;
            word_sr   <= '0;
            csum      <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            tx_start <= 1'b0;
            if (state == S_IDLE && state_n == S_LEN_LO) begin
                err      <= 1'b0;
                csum     <= '0;
                idx      <= '0;
                byte_cnt <= '0;
            end
            if (state == S_LEN_LO && rx_done_tick) len_lo <= rx_data;
            if (state == S_LEN_HI && rx_done_tick) len    <= len_in;
            if (state == S_DATA && rx_done_tick) begin
                word_sr  <= word_next;
                csum     <= csum ^ rx_data;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= word_addr;
                    mem_wdata <= word_next;
                    idx       <= idx + 16'd1;
                end
            end
            if (send_now) begin
                tx_start <= 1'b1;
                tx_data  <= send_byte;
            end
            if (state == S_WAIT_TX && tx_done_tick) begin
                if (tx_data == ACK) begin
                    done      <= 1'b1;
                    cpu_rst_n <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frame table, random frames against a
// frame-level reference model, plus timeout and mid-frame reset sequences.
module tb_uart_boot_loader;

    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_done_tick = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n, done, err;

    always #5 clk = ~clk;

    uart_boot_loader #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .done         (done),
        .err          (err)
    );

    logic [47:0] wq[$];
    logic [7:0]  txq[$];

    always @(negedge clk) begin
        if (mem_we)   wq.push_back({mem_addr, mem_wdata});
        if (tx_start) txq.push_back(tx_data);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: parse a complete frame into expected writes and reply.
    logic [7:0]  frame[$];
    logic [47:0] exp_w[$];
    logic [7:0]  exp_reply;

    task automatic model();
        int p = 0;
        int len;
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        exp_w.delete();
        while (p < frame.size() && frame[p] != 8'hA5) p++;
        len = int'(frame[p+1]) + 256 * int'(frame[p+2]);
        if (len == 0 || len > 1024) begin
            exp_reply = 8'h15;
            return;
        end
        for (int i = 0; i < len; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w = w | (32'(frame[p+3+4*i+k]) << (8*k));
                x = x ^ frame[p+3+4*i+k];
            end
            exp_w.push_back({16'(4*i), w});
        end
        exp_reply = (frame[p+3+4*len] == x) ? 8'h06 : 8'h15;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rx_done_tick = 1'b0; tx_done_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b; rx_done_tick = 1'b1;
        @(posedge clk);
        #1 rx_done_tick = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO + 100; i++) begin
            @(negedge clk); #1;
            if (txq.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_tx_done();
        repeat (3) @(posedge clk);
        #1 tx_done_tick = 1'b1;
        @(posedge clk);
        #1 tx_done_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string nm, input bit has_tbl, input logic [7:0] t_reply,
                             input int t_nw);
        bit ok;
        bit ack;
        do_reset();
        wq.delete(); txq.delete();
        model();
        ack = (exp_reply == 8'h06);
        foreach (frame[i]) send_byte(frame[i]);
        wait_tx(1, ok);
        chk({nm, "/tx_seen"}, 64'(ok), 64'd1);
        send_byte(8'hA5);  // lands in WAIT_TX and must be dropped
        pulse_tx_done();
        if (has_tbl) begin
            chk({nm, "/tbl_reply"}, 64'(exp_reply), 64'(t_reply));
            chk({nm, "/tbl_nw"}, 64'(wq.size()), 64'(t_nw));
        end
        chk({nm, "/tx_cnt"}, 64'(txq.size()), 64'd1);
        chk({nm, "/reply"}, 64'((txq.size() > 0) ? txq[0] : 8'h00), 64'(exp_reply));
        chk({nm, "/nwrites"}, 64'(wq.size()), 64'(exp_w.size()));
        for (int i = 0; i < wq.size() && i < exp_w.size(); i++)
            chk($sformatf("%s/write%0d", nm, i), 64'(wq[i]), 64'(exp_w[i]));
        chk({nm, "/done"}, 64'(done), 64'(ack));
        chk({nm, "/cpu_rst_n"}, 64'(cpu_rst_n), 64'(ack));
        chk({nm, "/err"}, 64'(err), 64'(!ack));
        if (ack) begin
            send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
            repeat (4) send_byte(8'h00);
            send_byte(8'h00);
            repeat (5) @(posedge clk);
            #1;
            chk({nm, "/post_done_w"}, 64'(wq.size()), 64'(exp_w.size()));
            chk({nm, "/post_done_tx"}, 64'(txq.size()), 64'd1);
            chk({nm, "/post_done_cpu"}, 64'(cpu_rst_n), 64'd1);
        end
    endtask

    typedef struct {
        int           n;
        logic [127:0] bytes;
        logic [7:0]   reply;
        int           nw;
    } vec_t;

    vec_t vt[5];

    task automatic load_good_frame();
        frame.delete();
        frame = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int len;
        logic [7:0] b, x;

        vt[0] = '{12, 128'hA5020011223344556677888800000000, 8'h06, 2};
        vt[1] = '{12, 128'hA5020011223344556677880000000000, 8'h15, 2};
        vt[2] = '{11, 128'h00FF3CA50100DEADBEEF220000000000, 8'h06, 1};
        vt[3] = '{3,  128'hA5000000000000000000000000000000, 8'h15, 0};
        vt[4] = '{3,  128'hA5010400000000000000000000000000, 8'h15, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst/tx_start", 64'(tx_start), 64'd0);
        chk("rst/tx_data", 64'(tx_data), 64'h00);
        chk("rst/mem_we", 64'(mem_we), 64'd0);
        chk("rst/mem_addr", 64'(mem_addr), 64'h0000);
        chk("rst/mem_wdata", 64'(mem_wdata), 64'h0);
        chk("rst/cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("rst/done", 64'(done), 64'd0);
        chk("rst/err", 64'(err), 64'd0);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            frame.delete();
            for (int i = 0; i < vt[v].n; i++) frame.push_back(vt[v].bytes[127-8*i -: 8]);
            run_frame($sformatf("vec%0d", v), 1'b1, vt[v].reply, vt[v].nw);
        end

        // Random frames against the model
        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(1, 6);
            frame.delete();
            frame.push_back(8'hA5); frame.push_back(8'(len)); frame.push_back(8'h00);
            x = 8'h00;
            for (int i = 0; i < 4 * len; i++) begin
                b = 8'($urandom);
                frame.push_back(b);
                x = x ^ b;
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            frame.push_back(x);
            run_frame($sformatf("rnd%0d", r), 1'b0, 8'h00, 0);
        end

        // Timeout mid-DATA, then recovery on a fresh frame without reset
        do_reset();
        wq.delete(); txq.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        wait_tx(1, ok);
        chk("tmo/tx_seen", 64'(ok), 64'd1);
        chk("tmo/reply", 64'((txq.size() > 0) ? txq[0] : 8'h00), 64'h15);
        pulse_tx_done();
        chk("tmo/nwrites", 64'(wq.size()), 64'd0);
        chk("tmo/err", 64'(err), 64'd1);
        chk("tmo/done", 64'(done), 64'd0);
        load_good_frame();
        send_byte(frame[0]);
        chk("tmo/err_cleared", 64'(err), 64'd0);
        for (int i = 1; i < frame.size(); i++) send_byte(frame[i]);
        wait_tx(2, ok);
        chk("tmo/recover_seen", 64'(ok), 64'd1);
        chk("tmo/recover_reply", 64'((txq.size() > 1) ? txq[1] : 8'h00), 64'h06);
        pulse_tx_done();
        chk("tmo/recover_write", 64'((wq.size() > 0) ? wq[0] : 48'h0), 64'h0000_EFBEADDE);
        chk("tmo/recover_done", 64'(done), 64'd1);

        // Reset asserted mid-DATA
        do_reset();
        wq.delete(); txq.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("rstmid/outs", 64'({tx_start, tx_data, mem_we, mem_wdata, cpu_rst_n, done, err}),
            64'h0);
        chk("rstmid/mem_addr", 64'(mem_addr), 64'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid/no_we", 64'(wq.size()), 64'd0);
        chk("rstmid/no_tx", 64'(txq.size()), 64'd0);
        load_good_frame();
        foreach (frame[i]) send_byte(frame[i]);
        wait_tx(1, ok);
        chk("rstmid/reply", 64'((txq.size() > 0) ? txq[0] : 8'h00), 64'h06);
        pulse_tx_done();
        chk("rstmid/write", 64'((wq.size() > 0) ? wq[0] : 48'h0), 64'h0000_EFBEADDE);
        chk("rstmid/cpu_rst_n", 64'(cpu_rst_n), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
